management_rx_fifo: RTL

MANAGEMENT_RX_FIFO -- requirements
Module: management_rx_fifo

---
 rtl/management_rx_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/management_rx_fifo.sv
// Receive frame FIFO: byte buffer plus frame-length queue; frames become readable only once committed.
// Optional drop counter port/logic built when MGMT_RX_DROP_COUNTER_EN is defined.
module management_rx_fifo #(
  parameter int unsigned DATA_DEPTH = 4096,
  parameter int unsigned LEN_DEPTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_start,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  output logic        rd_frame_valid,
  output logic [10:0] rd_frame_len,
  input  logic        rd_en,
  output logic        rd_data_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_pop
`ifdef MGMT_RX_DROP_COUNTER_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned AW  = $clog2(DATA_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned LAW = $clog2(LEN_DEPTH);
  localparam int unsigned LW  = LAW + 1;
  localparam int unsigned LENW = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_OVF  = 2'd2;

  logic [7:0]      data_mem [DATA_DEPTH];
  logic [LENW-1:0] len_mem  [LEN_DEPTH];

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   cptr_q, cptr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [PW-1:0]   rptr_q;
  logic [LENW-1:0] rcnt_q;
  logic [LW-1:0]   lwp_q, lrp_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;

  logic            mem_we_c, lpush_c, discard_c, overflow_c;
  logic            buf_full_c, lfifo_full_c, lfifo_empty_c;
  logic            rd_accept_c, pop_c;
  logic [LENW-1:0] head_len_c;
  logic [AW-1:0]   raddr_c;

  // Space held by uncommitted bytes counts as used, so a tentative frame is never overwritten.
  assign buf_full_c    = (wptr_q - rptr_q) == PW'(DATA_DEPTH);
  assign lfifo_empty_c = (lwp_q == lrp_q);
  assign lfifo_full_c  = (lwp_q - lrp_q) == LW'(LEN_DEPTH);
  assign head_len_c    = len_mem[lrp_q[LAW-1:0]];
  assign rd_accept_c   = rd_en && !lfifo_empty_c && (rcnt_q < head_len_c) && !rd_pop;
  assign pop_c         = rd_pop && !lfifo_empty_c;
  assign raddr_c       = rptr_q[AW-1:0] + AW'(rcnt_q);

  assign rd_frame_valid = !lfifo_empty_c;
  assign rd_frame_len   = head_len_c;
  assign rd_data_valid  = rd_valid_q;
  assign rd_data        = rd_data_q;

  // Write-side next state: rx_start beats rx_drop beats data/commit.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    len_d      = len_q;
    mem_we_c   = 1'b0;
    lpush_c    = 1'b0;
    discard_c  = 1'b0;
    overflow_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_start) begin
          state_d = ST_RECV;
          wptr_d  = cptr_q;
          len_d   = '0;
        end
      end
      ST_RECV: begin
        if (rx_start) begin
          discard_c = 1'b1;
          len_d     = '0;
        end else if (rx_drop) begin
          discard_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          if (rx_data_valid) begin
            if (buf_full_c || (len_q == {LENW{1'b1}})) begin
              overflow_c = 1'b1;
            end else begin
              mem_we_c = 1'b1;
              wptr_d   = wptr_q + PW'(1);
              len_d    = len_q + LENW'(1);
            end
          end
          if (rx_commit) begin
            if (!overflow_c && (len_d != '0) && !lfifo_full_c) begin
              lpush_c = 1'b1;
              cptr_d  = wptr_d;
            end else begin
              discard_c = 1'b1;
            end
            state_d = ST_IDLE;
          end else if (overflow_c) begin
            state_d = ST_OVF;
          end
        end
      end
      ST_OVF: begin
        // A restart abandons the overflowed frame, which is counted like any other discard.
        if (rx_start) begin
          discard_c = 1'b1;
          len_d     = '0;
          state_d   = ST_RECV;
        end else if (rx_drop || rx_commit) begin
          discard_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wptr_d  = cptr_q;
      end
    endcase
    if (discard_c) wptr_d = cptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cptr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      len_q   <= len_d;
    end
  end

  // Storage arrays carry no reset; pointer reset alone invalidates their contents.
  always_ff @(posedge clk) begin
    if (mem_we_c) data_mem[wptr_q[AW-1:0]] <= rx_data;
    if (lpush_c)  len_mem[lwp_q[LAW-1:0]]  <= len_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lwp_q      <= '0;
      lrp_q      <= '0;
      rptr_q     <= '0;
      rcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept_c;
      if (rd_accept_c) rd_data_q <= data_mem[raddr_c];
      if (lpush_c) lwp_q <= lwp_q + LW'(1);
      if (pop_c) begin
        lrp_q  <= lrp_q + LW'(1);
        rptr_q <= rptr_q + PW'(head_len_c);
        rcnt_q <= '0;
      end else if (rd_accept_c) begin
        rcnt_q <= rcnt_q + LENW'(1);
      end
    end
  end

`ifdef MGMT_RX_DROP_COUNTER_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (discard_c && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
